// File: rtl/cache_system_wb_if.sv
// rtl/cache_system_wb_if.sv - CPU request, memory and status signals of the write-back cache
interface cache_system_wb_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  cpu_addr;
  logic [DATA_WIDTH-1:0]  cpu_data_in;
  logic                   cpu_req;
  logic                   cpu_wen;
  logic [DATA_WIDTH-1:0]  cpu_data_out;
  logic                   cpu_ready;
  logic                   flush;
  logic                   flush_done;
  logic                   busy;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_data_in;
  logic [DATA_WIDTH-1:0]  mem_data_out;
  logic                   mem_wen;
  logic                   mem_ren;
  logic                   mem_ready;
  logic [COUNT_WIDTH-1:0] hit_count;
  logic [COUNT_WIDTH-1:0] miss_count;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_req, cpu_wen, flush, mem_data_out, mem_ready,
    output cpu_data_out, cpu_ready, flush_done, busy, mem_addr, mem_data_in,
           mem_wen, mem_ren, hit_count, miss_count
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_req, cpu_wen, flush, mem_data_out, mem_ready,
    input  cpu_data_out, cpu_ready, flush_done, busy, mem_addr, mem_data_in,
           mem_wen, mem_ren, hit_count, miss_count
  );
endinterface

// File: rtl/cache_system_wb.sv
// rtl/cache_system_wb.sv - 2-way set-associative write-back, write-allocate cache with LRU, flush and hit/miss counters
module cache_system_wb #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int COUNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  cache_system_wb_if.slave bus
);
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITEBACK, S_FILL, S_RESPOND, S_FLUSH_SCAN, S_FLUSH_WB, S_FLUSH_DONE
  } state_t;

  state_t r_state, w_next;

  logic [TAG_BITS-1:0]    r_tag  [2][SETS];
  logic [DATA_WIDTH-1:0]  r_data [2][SETS];
  logic [1:0][SETS-1:0]   r_valid, r_dirty;
  logic [SETS-1:0]        r_lru;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
  logic                   r_wen, r_way;
  logic [INDEX_BITS:0]    r_scan;
  logic [COUNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt;

  logic [INDEX_BITS-1:0]  w_index, w_scan_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic w_hit0, w_hit1, w_hit, w_victim, w_scan_way, w_scan_dirty, w_scan_last;

  assign w_index      = r_addr[INDEX_BITS-1:0];
  assign w_tag        = r_addr[ADDR_WIDTH-1:INDEX_BITS];
  assign w_hit0       = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
  assign w_hit1       = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
  assign w_hit        = w_hit0 || w_hit1;
  // r_lru holds the way to replace next once both ways are valid
  assign w_victim     = !r_valid[0][w_index] ? 1'b0 :
                        !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
  // scan counter is {set, way} so way toggles fastest
  assign w_scan_idx   = r_scan[INDEX_BITS:1];
  assign w_scan_way   = r_scan[0];
  assign w_scan_dirty = r_valid[w_scan_way][w_scan_idx] && r_dirty[w_scan_way][w_scan_idx];
  assign w_scan_last  = &r_scan;

  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

  always_comb begin
    w_next           = r_state;
    bus.cpu_ready    = 1'b0;
    bus.cpu_data_out = '0;
    bus.flush_done   = 1'b0;
    bus.mem_wen      = 1'b0;
    bus.mem_ren      = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_in  = '0;
    bus.busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.flush)        w_next = S_FLUSH_SCAN;
        else if (bus.cpu_req) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit)                                                 w_next = S_RESPOND;
        else if (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index]) w_next = S_WRITEBACK;
        else                                                       w_next = S_FILL;
      end
      S_WRITEBACK: begin
        bus.mem_wen     = 1'b1;
        bus.mem_addr    = {r_tag[r_way][w_index], w_index};
        bus.mem_data_in = r_data[r_way][w_index];
        if (bus.mem_ready) w_next = S_FILL;
      end
      S_FILL: begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = r_addr;
        if (bus.mem_ready) w_next = S_RESPOND;
      end
      S_RESPOND: begin
        bus.cpu_ready    = 1'b1;
        bus.cpu_data_out = r_rdata;
        w_next           = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (w_scan_dirty)     w_next = S_FLUSH_WB;
        else if (w_scan_last) w_next = S_FLUSH_DONE;
      end
      S_FLUSH_WB: begin
        bus.mem_wen     = 1'b1;
        bus.mem_addr    = {r_tag[w_scan_way][w_scan_idx], w_scan_idx};
        bus.mem_data_in = r_data[w_scan_way][w_scan_idx];
        if (bus.mem_ready) w_next = w_scan_last ? S_FLUSH_DONE : S_FLUSH_SCAN;
      end
      S_FLUSH_DONE: begin
        bus.flush_done = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_lru      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wen      <= 1'b0;
      r_way      <= 1'b0;
      r_scan     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_scan <= '0;
          if (!bus.flush && bus.cpu_req) begin
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_data_in;
            r_wen   <= bus.cpu_wen;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_way          <= w_hit1;
            r_lru[w_index] <= ~w_hit1;
            r_rdata        <= r_wen ? r_wdata : r_data[w_hit1][w_index];
            if (r_wen) r_dirty[w_hit1][w_index] <= 1'b1;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            r_way <= w_victim;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (bus.mem_ready) begin
            r_valid[r_way][w_index] <= 1'b1;
            r_dirty[r_way][w_index] <= r_wen;
            r_lru[w_index]          <= ~r_way;
            r_rdata                 <= r_wen ? r_wdata : bus.mem_data_out;
          end
        end
        S_FLUSH_SCAN: begin
          if (!w_scan_dirty) r_scan <= r_scan + 1'b1;
        end
        S_FLUSH_WB: begin
          if (bus.mem_ready) begin
            r_dirty[w_scan_way][w_scan_idx] <= 1'b0;
            r_scan                          <= r_scan + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // line storage is qualified by r_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (r_state == S_COMPARE && w_hit && r_wen)
      r_data[w_hit1][w_index] <= r_wdata;
    if (r_state == S_FILL && bus.mem_ready) begin
      r_tag[r_way][w_index]  <= w_tag;
      r_data[r_way][w_index] <= r_wen ? r_wdata : bus.mem_data_out;
    end
  end
endmodule

// File: tb/tb_cache_system_wb.sv
// tb/tb_cache_system_wb.sv - directed self-checking bench for cache_system_wb
module tb_cache_system_wb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_system_wb_if bus ();
  cache_system_wb dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  bit zero_wait = 1'b0;
  int mcnt = 0;

  logic [15:0] log_addr [$];
  bit          log_we   [$];
  logic [31:0] log_data [$];

  // memory: mem[a] = a + 0x1000, ack in the third strobe cycle or immediately when zero_wait
  initial begin
    bus.mem_ready    = 1'b0;
    bus.mem_data_out = '0;
    forever begin
      @(negedge clk);
      bus.mem_data_out = 32'(bus.mem_addr) + 32'h1000;
      if (rst && (bus.mem_wen || bus.mem_ren)) begin
        mcnt++;
        if (zero_wait || mcnt >= 3) begin
          bus.mem_ready = 1'b1;
          mcnt = 0;
          log_addr.push_back(bus.mem_addr);
          log_we.push_back(bus.mem_wen);
          log_data.push_back(bus.mem_wen ? bus.mem_data_in : bus.mem_data_out);
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        mcnt = 0;
        bus.mem_ready = zero_wait;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.flush = 1'b0;
    bus.cpu_addr = '0; bus.cpu_data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_log();
  endtask

  task automatic cpu_op(input logic [15:0] a, input bit we, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_wen = we; bus.cpu_data_in = d; bus.cpu_req = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = k;
        rd  = bus.cpu_data_out;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL cpu_timeout: addr %h got no cpu_ready within 300 cycles", a);
    end
  endtask

  task automatic do_flush(output bit seen);
    seen = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.flush_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.flush = 1'b1; bus.cpu_wen = 1'b0;
    bus.cpu_addr = 16'h0010; bus.cpu_data_in = 32'h1234;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if ({bus.mem_wen, bus.mem_ren, bus.cpu_ready, bus.flush_done} !== 4'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b want 0000", {bus.mem_wen, bus.mem_ren, bus.cpu_ready, bus.flush_done}); end
    n_vec++; if ({bus.hit_count, bus.miss_count} !== 32'h0) begin
      n_err++; $display("FAIL rst_counters: got %h want 0", {bus.hit_count, bus.miss_count}); end
    n_vec++; if ({bus.mem_addr, bus.mem_data_in, bus.cpu_data_out} !== 80'h0) begin
      n_err++; $display("FAIL rst_data_outs: got %h want 0", {bus.mem_addr, bus.mem_data_in, bus.cpu_data_out}); end
    bus.cpu_req = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    clear_log();
    cpu_op(16'h0010, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1010) begin n_err++; $display("FAIL rst_first_read: got %h want 00001010", rd); end
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] rd;
    int lat;
    apply_reset();
    cpu_op(16'h0010, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1010) begin n_err++; $display("FAIL miss_data: got %h want 00001010", rd); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL miss_latency: got %0d want 5", lat); end
    n_vec++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 16'h0010) begin
      n_err++; $display("FAIL miss_mem_read: got %0d transfers want one read at 0010", log_addr.size()); end
    cpu_op(16'h0010, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1010) begin n_err++; $display("FAIL hit_data: got %h want 00001010", rd); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", lat); end
    n_vec++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL hit_no_mem: got %0d transfers want 1", log_addr.size()); end
    n_vec++; if (bus.hit_count !== 16'd1 || bus.miss_count !== 16'd1) begin
      n_err++; $display("FAIL mh_counters: got hit %0d miss %0d want 1 1", bus.hit_count, bus.miss_count); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd;
    int lat;
    apply_reset();
    cpu_op(16'h0005, 1'b1, 32'hDEAD_BEEF, rd, lat);
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_echo: got %h want deadbeef", rd); end
    cpu_op(16'h0045, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1045) begin n_err++; $display("FAIL way1_fill: got %h want 00001045", rd); end
    cpu_op(16'h0085, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1085) begin n_err++; $display("FAIL evict_data: got %h want 00001085", rd); end
    n_vec++;
    if (log_addr.size() !== 4) begin
      n_err++; $display("FAIL evict_count: got %0d transfers want 4", log_addr.size());
    end else if (!(log_we[2] && log_addr[2] == 16'h0005 && log_data[2] == 32'hDEAD_BEEF &&
                   !log_we[3] && log_addr[3] == 16'h0085)) begin
      n_err++; $display("FAIL evict_seq: got we%0d %h %h / we%0d %h want we1 0005 deadbeef / we0 0085",
                        log_we[2], log_addr[2], log_data[2], log_we[3], log_addr[3]);
    end
    cpu_op(16'h0045, 1'b0, 32'h0, rd, lat);
    n_vec++; if (lat !== 2 || rd !== 32'h0000_1045) begin
      n_err++; $display("FAIL survivor_hit: got lat %0d data %h want 2 00001045", lat, rd); end
    n_vec++; if (bus.hit_count !== 16'd1 || bus.miss_count !== 16'd3) begin
      n_err++; $display("FAIL evict_counters: got hit %0d miss %0d want 1 3", bus.hit_count, bus.miss_count); end
  endtask

  task automatic test_lru();
    logic [31:0] rd;
    int lat;
    apply_reset();
    cpu_op(16'h0005, 1'b0, 32'h0, rd, lat);
    cpu_op(16'h0045, 1'b0, 32'h0, rd, lat);
    cpu_op(16'h0005, 1'b0, 32'h0, rd, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL lru_rehit: got lat %0d want 2", lat); end
    cpu_op(16'h0085, 1'b0, 32'h0, rd, lat);
    n_vec++; if (log_addr.size() !== 3 || log_we[0] || log_we[1] || log_we[2] || log_addr[2] !== 16'h0085) begin
      n_err++; $display("FAIL lru_clean_evict: got %0d transfers want 3 reads ending at 0085", log_addr.size()); end
    cpu_op(16'h0005, 1'b0, 32'h0, rd, lat);
    n_vec++; if (lat !== 2 || rd !== 32'h0000_1005) begin
      n_err++; $display("FAIL lru_keep_mru: got lat %0d data %h want 2 00001005", lat, rd); end
    n_vec++; if (bus.hit_count !== 16'd2 || bus.miss_count !== 16'd3) begin
      n_err++; $display("FAIL lru_counters: got hit %0d miss %0d want 2 3", bus.hit_count, bus.miss_count); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    int lat;
    bit seen;
    apply_reset();
    cpu_op(16'h0001, 1'b1, 32'h0000_000A, rd, lat);
    cpu_op(16'h0002, 1'b1, 32'h0000_000B, rd, lat);
    clear_log();
    do_flush(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL flush_done1: got no pulse want pulse"); end
    n_vec++;
    if (log_addr.size() !== 2) begin
      n_err++; $display("FAIL flush_count: got %0d transfers want 2", log_addr.size());
    end else if (!(log_we[0] && log_addr[0] == 16'h0001 && log_data[0] == 32'hA &&
                   log_we[1] && log_addr[1] == 16'h0002 && log_data[1] == 32'hB)) begin
      n_err++; $display("FAIL flush_seq: got %h=%h %h=%h want 0001=a 0002=b",
                        log_addr[0], log_data[0], log_addr[1], log_data[1]);
    end
    clear_log();
    do_flush(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL flush_done2: got no pulse want pulse"); end
    n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL flush_clean: got %0d writes want 0", log_addr.size()); end
    cpu_op(16'h0001, 1'b0, 32'h0, rd, lat);
    n_vec++; if (lat !== 2 || rd !== 32'h0000_000A) begin
      n_err++; $display("FAIL flush_keeps_valid: got lat %0d data %h want 2 0000000a", lat, rd); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int lat;
    bit found;
    apply_reset();
    found = 1'b0;
    @(negedge clk);
    bus.cpu_addr = 16'h0020; bus.cpu_wen = 1'b0; bus.cpu_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_ren) begin found = 1'b1; break; end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_fill_start: got no mem_ren want mem_ren"); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.mem_ren !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL mid_fill_abort: got ren %b busy %b want 0 0", bus.mem_ren, bus.busy); end
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cpu_op(16'h0020, 1'b0, 32'h0, rd, lat);
    n_vec++; if (rd !== 32'h0000_1020 || bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
      n_err++; $display("FAIL mid_fill_refetch: got %h miss %0d hit %0d want 00001020 1 0", rd, bus.miss_count, bus.hit_count); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    int lat, fd_at, rdy_at;
    apply_reset();
    zero_wait = 1'b1;
    cpu_op(16'h0030, 1'b0, 32'h0, rd, lat);
    n_vec++; if (lat !== 3 || rd !== 32'h0000_1030) begin
      n_err++; $display("FAIL zw_miss: got lat %0d data %h want 3 00001030", lat, rd); end
    cpu_op(16'h0007, 1'b1, 32'h0000_0077, rd, lat);
    clear_log();
    fd_at = 0; rdy_at = 0; rd = '0;
    @(negedge clk);
    bus.flush = 1'b1;
    bus.cpu_addr = 16'h0008; bus.cpu_wen = 1'b0; bus.cpu_req = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      if (bus.flush_done && fd_at == 0) fd_at = k;
      if (bus.cpu_ready) begin rdy_at = k; rd = bus.cpu_data_out; break; end
      @(negedge clk);
    end
    bus.cpu_req = 1'b0;
    n_vec++; if (fd_at == 0 || rdy_at <= fd_at) begin
      n_err++; $display("FAIL flush_first: got flush_done at %0d ready at %0d want done before ready", fd_at, rdy_at); end
    n_vec++; if (rd !== 32'h0000_1008) begin n_err++; $display("FAIL pending_req_data: got %h want 00001008", rd); end
    n_vec++;
    if (log_addr.size() !== 2) begin
      n_err++; $display("FAIL zw_seq_count: got %0d transfers want 2", log_addr.size());
    end else if (!(log_we[0] && log_addr[0] == 16'h0007 && log_data[0] == 32'h77 &&
                   !log_we[1] && log_addr[1] == 16'h0008)) begin
      n_err++; $display("FAIL zw_seq: got we%0d %h %h / we%0d %h want we1 0007 77 / we0 0008",
                        log_we[0], log_addr[0], log_data[0], log_we[1], log_addr[1]);
    end
    zero_wait = 1'b0;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.flush = 1'b0;
    bus.cpu_addr = '0; bus.cpu_data_in = '0;
    test_reset();
    test_read_miss_hit();
    test_dirty_evict();
    test_lru();
    test_flush();
    test_reset_mid_fill();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
